// File: rtl/uctl_cmdifrouter.sv
// Command-interface router: decodes a command address against NUM_RGN windows,
// then steers the following write/read beats to the latched region with address auto-increment.

module uctl_cmdifrouter_win #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] LIMIT  = '1
) (
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [ADDR_W-1:0] beat_addr_i,
    output logic              hit_o,
    output logic              over_o
);
    assign hit_o  = (cmd_addr_i >= BASE) && (cmd_addr_i <= LIMIT);
    assign over_o = (beat_addr_i > LIMIT);
endmodule

module uctl_cmdifrouter #(
    parameter int                        NUM_RGN   = 3,
    parameter int                        ADDR_W    = 32,
    parameter int                        DATA_W    = 32,
    parameter logic [NUM_RGN*ADDR_W-1:0] RGN_BASE  = {32'h0000_1000, 32'h0000_0800, 32'h0000_0920},
    parameter logic [NUM_RGN*ADDR_W-1:0] RGN_LIMIT = {32'h0000_1FFF, 32'h0000_091B, 32'h0000_0D1F},
    parameter int                        ADDR_INCR = 4
) (
    input  logic                        sys_clk,
    input  logic                        sw_rst,
    input  logic                        cmdIf_trEn,
    input  logic                        cmdIf_req,
    input  logic [ADDR_W-1:0]           cmdIf_addr,
    input  logic                        cmdIf_wrRd,
    output logic                        cmdIf_ack,
    output logic                        cmdIf_err,
    input  logic                        cmdIf_wrData_req,
    input  logic [DATA_W-1:0]           cmdIf_wrData,
    output logic                        cmdIf_wrData_ack,
    input  logic                        cmdIf_rdData_req,
    output logic                        cmdIf_rdData_ack,
    output logic [DATA_W-1:0]           cmdIf_rdData,
    output logic [ADDR_W-1:0]           rgn_addr,
    output logic [DATA_W-1:0]           rgn_wrData,
    output logic [NUM_RGN-1:0]          rgn_wrReq,
    output logic [NUM_RGN-1:0]          rgn_rdReq,
    input  logic [NUM_RGN*DATA_W-1:0]   rgn_rdData,
    output logic [2:0]                  rgn_sel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          sel_q;
    logic                rd_pend_q;
    logic                rd_err_q;
    logic                carry_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic [NUM_RGN-1:0]  hit;
    logic [NUM_RGN-1:0]  over;
    logic [NUM_RGN-1:0]  sel_oh;
    logic                any_hit;
    logic [2:0]          win;
    logic                sel_over;
    logic [DATA_W-1:0]   rd_mux;
    logic                beat_err;
    logic [ADDR_W-1:0]   addr_d;
    logic                carry_d;
    logic                do_cmd;
    logic                do_wr;
    logic                do_rd;
    logic                go_idle;

    // direction hint is informational only
    logic unused_wrrd;
    assign unused_wrrd = cmdIf_wrRd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RGN; gi++) begin : g_win
            uctl_cmdifrouter_win #(
                .ADDR_W (ADDR_W),
                .BASE   (RGN_BASE [gi*ADDR_W +: ADDR_W]),
                .LIMIT  (RGN_LIMIT[gi*ADDR_W +: ADDR_W])
            ) u_win (
                .cmd_addr_i  (cmdIf_addr),
                .beat_addr_i (addr_q),
                .hit_o       (hit[gi]),
                .over_o      (over[gi])
            );
        end
    endgenerate

    // lowest hitting index wins on overlapping windows
    always_comb begin
        win     = '0;
        any_hit = |hit;
        for (int i = NUM_RGN - 1; i >= 0; i--) begin
            if (hit[i]) win = 3'(i);
        end
    end

    always_comb begin
        sel_oh   = '0;
        sel_over = 1'b0;
        rd_mux   = '0;
        for (int i = 0; i < NUM_RGN; i++) begin
            if (sel_q == 3'(i)) begin
                sel_oh[i] = 1'b1;
                sel_over  = over[i];
                rd_mux    = rgn_rdData[i*DATA_W +: DATA_W];
            end
        end
    end

    // carry out of the increment sticks until the next command load
    assign {carry_d, addr_d} = {1'b0, addr_q} + (ADDR_W+1)'(ADDR_INCR);
    assign beat_err = (state_q == S_ERR) || sel_over || carry_q;

    always_comb begin
        do_cmd  = 1'b0;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        go_idle = 1'b0;
        if (!sw_rst && !rd_pend_q) begin
            case (state_q)
                S_IDLE: do_cmd = cmdIf_trEn && cmdIf_req;
                S_ACTIVE, S_ERR: begin
                    if (cmdIf_trEn && cmdIf_wrData_req)      do_wr   = 1'b1;
                    else if (cmdIf_trEn && cmdIf_rdData_req) do_rd   = 1'b1;
                    else if (cmdIf_trEn && cmdIf_req)        do_cmd  = 1'b1;
                    else                                     go_idle = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmdIf_ack        = do_cmd;
    assign cmdIf_wrData_ack = do_wr;
    assign cmdIf_rdData_ack = rd_pend_q;
    assign cmdIf_rdData     = rd_data_q;
    assign cmdIf_err        = (do_cmd && !any_hit) || (do_wr && beat_err) || (rd_pend_q && rd_err_q);
    assign rgn_wrReq        = (do_wr && !beat_err) ? sel_oh : '0;
    assign rgn_rdReq        = (do_rd && !beat_err) ? sel_oh : '0;
    assign rgn_addr         = addr_q;
    assign rgn_wrData       = cmdIf_wrData;
    assign rgn_sel          = sel_q;

    always_ff @(posedge sys_clk) begin
        if (sw_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_err_q  <= 1'b0;
            carry_q   <= 1'b0;
            rd_data_q <= '0;
        end else if (rd_pend_q) begin
            // second read cycle always completes, regardless of new requests
            rd_pend_q <= 1'b0;
            addr_q    <= addr_d;
            carry_q   <= carry_q | carry_d;
        end else if (do_cmd) begin
            addr_q  <= cmdIf_addr;
            carry_q <= 1'b0;
            if (any_hit) begin
                sel_q   <= win;
                state_q <= S_ACTIVE;
            end else begin
                state_q <= S_ERR;
            end
        end else if (do_wr) begin
            addr_q  <= addr_d;
            carry_q <= carry_q | carry_d;
        end else if (do_rd) begin
            rd_pend_q <= 1'b1;
            rd_err_q  <= beat_err;
            rd_data_q <= beat_err ? '0 : rd_mux;
        end else if (go_idle) begin
            state_q <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_uctl_cmdifrouter.sv
// Randomised scoreboard bench for uctl_cmdifrouter: a transaction-level model queues
// the expected output events, a negedge monitor pops and compares them.

module tb_uctl_cmdifrouter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              sys_clk = 1'b0;
    logic              sw_rst;
    logic              cmdIf_trEn, cmdIf_req, cmdIf_wrRd;
    logic [AW-1:0]     cmdIf_addr;
    logic              cmdIf_ack, cmdIf_err;
    logic              cmdIf_wrData_req, cmdIf_wrData_ack;
    logic [DW-1:0]     cmdIf_wrData;
    logic              cmdIf_rdData_req, cmdIf_rdData_ack;
    logic [DW-1:0]     cmdIf_rdData;
    logic [AW-1:0]     rgn_addr;
    logic [DW-1:0]     rgn_wrData;
    logic [NR-1:0]     rgn_wrReq, rgn_rdReq;
    logic [NR*DW-1:0]  rgn_rdData;
    logic [2:0]        rgn_sel;

    always #5 sys_clk = ~sys_clk;

    uctl_cmdifrouter dut (
        .sys_clk          (sys_clk),
        .sw_rst           (sw_rst),
        .cmdIf_trEn       (cmdIf_trEn),
        .cmdIf_req        (cmdIf_req),
        .cmdIf_addr       (cmdIf_addr),
        .cmdIf_wrRd       (cmdIf_wrRd),
        .cmdIf_ack        (cmdIf_ack),
        .cmdIf_err        (cmdIf_err),
        .cmdIf_wrData_req (cmdIf_wrData_req),
        .cmdIf_wrData     (cmdIf_wrData),
        .cmdIf_wrData_ack (cmdIf_wrData_ack),
        .cmdIf_rdData_req (cmdIf_rdData_req),
        .cmdIf_rdData_ack (cmdIf_rdData_ack),
        .cmdIf_rdData     (cmdIf_rdData),
        .rgn_addr         (rgn_addr),
        .rgn_wrData       (rgn_wrData),
        .rgn_wrReq        (rgn_wrReq),
        .rgn_rdReq        (rgn_rdReq),
        .rgn_rdData       (rgn_rdData),
        .rgn_sel          (rgn_sel)
    );

    // window map as seen by the master: region index -> [base, limit]
    longint BASE[NR] = '{64'h920, 64'h800, 64'h1000};
    longint LIM [NR] = '{64'hD1F, 64'h91B, 64'h1FFF};

    localparam int K_CMD = 0, K_WR = 1, K_RDREQ = 2, K_RDACK = 3;

    typedef struct {
        int          kind;
        bit          err;
        logic [2:0]  wr;
        logic [2:0]  rd;
        bit          chk_addr;
        logic [31:0] addr;
        logic [31:0] data;
        int          sel;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model state
    bit     m_act   = 0;
    bit     m_err   = 0;
    int     m_rgn   = 0;
    longint m_addr  = 0;
    bit     m_carry = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic void m_push(int kind, bit err, logic [2:0] wr, logic [2:0] rd,
                                   bit ca, longint a, logic [31:0] d, int sel);
        exp_t e;
        e.kind = kind; e.err = err; e.wr = wr; e.rd = rd;
        e.chk_addr = ca; e.addr = a[31:0]; e.data = d; e.sel = sel;
        q.push_back(e);
    endfunction

    function automatic bit m_berr();
        return m_err || (m_addr > LIM[m_rgn]) || m_carry;
    endfunction

    function automatic void m_inc();
        m_addr += 4;
        if (m_addr >= 64'h1_0000_0000) begin
            m_addr -= 64'h1_0000_0000;
            m_carry = 1;
        end
    endfunction

    function automatic void m_cmd(logic [31:0] a);
        int w = -1;
        for (int i = NR - 1; i >= 0; i--)
            if (longint'(a) >= BASE[i] && longint'(a) <= LIM[i]) w = i;
        m_push(K_CMD, w < 0, 3'b0, 3'b0, 0, 0, 0, -1);
        m_act = 1; m_err = (w < 0); m_addr = longint'(a); m_carry = 0;
        if (w >= 0) m_rgn = w;
    endfunction

    function automatic void m_wr();
        bit e;
        if (!m_act) return;
        e = m_berr();
        m_push(K_WR, e, e ? 3'b0 : 3'(1 << m_rgn), 3'b0, 1, m_addr, 0, e ? -1 : m_rgn);
        m_inc();
    endfunction

    function automatic void m_rd(logic [NR*DW-1:0] d);
        bit          e;
        logic [31:0] v;
        if (!m_act) return;
        e = m_berr();
        v = d[m_rgn*DW +: DW];
        if (!e) m_push(K_RDREQ, 0, 3'b0, 3'(1 << m_rgn), 1, m_addr, 0, m_rgn);
        m_push(K_RDACK, e, 3'b0, 3'b0, 1, m_addr, e ? 32'h0 : v, e ? -1 : m_rgn);
        m_inc();
    endfunction

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        if (!sw_rst) begin
            if (cmdIf_ack || cmdIf_wrData_ack || cmdIf_rdData_ack || (|rgn_wrReq) || (|rgn_rdReq)) begin
                int   k;
                exp_t e;
                k = cmdIf_ack ? K_CMD : cmdIf_wrData_ack ? K_WR : cmdIf_rdData_ack ? K_RDACK : K_RDREQ;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event kind=%0d at t=%0t (none required)", k, $time);
                end else begin
                    e = q.pop_front();
                    chk("kind", 64'(k), 64'(e.kind));
                    chk("err", 64'(cmdIf_err), 64'(e.err));
                    chk("strobes", {58'b0, rgn_wrReq, rgn_rdReq}, {58'b0, e.wr, e.rd});
                    if (e.chk_addr) chk("rgn_addr", 64'(rgn_addr), 64'(e.addr));
                    if (e.kind == K_RDACK) chk("rdData", 64'(cmdIf_rdData), 64'(e.data));
                    if (e.sel >= 0) chk("rgn_sel", 64'(rgn_sel), 64'(e.sel));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clr();
        cmdIf_trEn = 1; cmdIf_req = 0; cmdIf_wrData_req = 0; cmdIf_rdData_req = 0;
    endtask

    task automatic t_cmd(input logic [31:0] a);
        clr(); cmdIf_req = 1; cmdIf_addr = a; cmdIf_wrRd = $urandom_range(0, 1);
        m_cmd(a);
        cyc();
    endtask

    task automatic t_wr(input logic [31:0] d);
        clr(); cmdIf_wrData_req = 1; cmdIf_wrData = d;
        m_wr();
        cyc();
    endtask

    task automatic t_rd(input logic [NR*DW-1:0] d, input bit raise_wr);
        clr(); cmdIf_rdData_req = 1; rgn_rdData = d;
        m_rd(d);
        cyc();
        rgn_rdData = {$urandom, $urandom, $urandom};
        if (raise_wr) begin
            cmdIf_rdData_req = 0; cmdIf_wrData_req = 1; cmdIf_wrData = $urandom;
        end
        cyc();
    endtask

    task automatic t_idle();
        clr();
        if ($urandom_range(0, 1)) begin
            cmdIf_trEn = 0;
            cmdIf_req = $urandom_range(0, 1);
            cmdIf_wrData_req = $urandom_range(0, 1);
            cmdIf_rdData_req = $urandom_range(0, 1);
        end
        m_act = 0;
        cyc();
    endtask

    function automatic logic [31:0] pick_addr();
        int r = $urandom_range(0, NR - 1);
        logic [31:0] un[5] = '{32'h500, 32'h91C, 32'h2000, 32'h7FC, 32'hFFFF_FFFC};
        case ($urandom_range(0, 3))
            0:       return 32'(BASE[r] + 4 * $urandom_range(0, 8));
            1:       return 32'(LIM[r] + 1 - 4 * $urandom_range(1, 3));
            2:       return un[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    task automatic chk_all_zero(string nm);
        chk(nm, {cmdIf_ack, cmdIf_err, cmdIf_wrData_ack, cmdIf_rdData_ack, rgn_wrReq, rgn_rdReq, rgn_sel},
            64'h0);
        chk({nm, "_addr"}, 64'(rgn_addr), 64'h0);
        chk({nm, "_rdData"}, 64'(cmdIf_rdData), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        sw_rst = 1; clr(); cmdIf_trEn = 0; cmdIf_addr = 0; cmdIf_wrRd = 0;
        cmdIf_wrData = 0; rgn_rdData = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        sw_rst = 0;
        #3;
        chk_all_zero("reset");

        // region 1, three writes
        t_cmd(32'h800);
        t_wr(32'hA); t_wr(32'hB); t_wr(32'hC);
        // region 0, two held reads
        t_cmd(32'h920);
        t_rd({64'h0, 32'h11}, 0);
        t_rd({64'h0, 32'h22}, 0);
        // unmapped
        t_cmd(32'h500);
        t_wr(32'h1);
        t_rd({$urandom, $urandom, $urandom}, 0);
        // overrun at the end of region 1
        t_cmd(32'h918);
        t_wr(32'h5); t_wr(32'h6);
        // re-decode while active, then idle
        t_cmd(32'h920);
        t_wr(32'h7);
        t_cmd(32'h1004);
        t_wr(32'h8);
        t_idle();
        t_wr(32'h9);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            int op = $urandom_range(0, 9);
            if (op < 2)       t_cmd(pick_addr());
            else if (op < 5)  t_wr($urandom);
            else if (op < 8)  t_rd({$urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
            else if (op == 8) t_idle();
            else begin
                t_cmd(pick_addr());
                repeat ($urandom_range(1, 4)) t_wr($urandom);
            end
        end

        // reset during the first read cycle aborts the beat
        t_cmd(32'h920);
        clr(); cmdIf_rdData_req = 1; sw_rst = 1; m_act = 0;
        cyc();
        sw_rst = 0; clr(); cmdIf_trEn = 0;
        #3;
        chk_all_zero("midrst");
        cyc();
        t_wr(32'hDEAD);

        t_idle(); t_idle(); t_idle();
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uctl_cmdifrouter.md
Name: uctl_cmdIfRouter

Overview:
- Parametrised command-interface router.
- Decodes each cmdIf command address against NUM_RGN address windows and latches the matching region.
- Steers the following write/read data beats to that region's request strobes, auto-incrementing the address per beat.
- Flags unmapped commands and beats that run past the window limit with an error response instead of silently dropping them. Sits between the cmdIf master and the register bank, endpoint data and any further slave blocks.

Parameters:
NUM_RGN, 3, number of address windows/slave ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
RGN_BASE, {32'h0000_1000,32'h0000_0800,32'h0000_0920}, packed NUM_RGN*ADDR_W window bases; index 0 in LSBs
RGN_LIMIT, {32'h0000_1FFF,32'h0000_091B,32'h0000_0D1F}, packed inclusive window limits
ADDR_INCR, 4, per-beat address increment

Ports:
sys_clk  in  1  system clock
sw_rst  in  1  synchronous active-high reset
cmdIf_trEn  in  1  transfer enable; qualifies all cmdIf requests
cmdIf_req  in  1  command request
cmdIf_addr  in  ADDR_W  command start address
cmdIf_wrRd  in  1  direction hint (informational, not used for steering)
cmdIf_ack  out  1  command accepted (combinational)
cmdIf_err  out  1  error qualifier, valid with cmdIf_ack, cmdIf_wrData_ack, cmdIf_rdData_ack
cmdIf_wrData_req  in  1  write beat request
cmdIf_wrData  in  DATA_W  write beat data
cmdIf_wrData_ack  out  1  write beat accepted (combinational)
cmdIf_rdData_req  in  1  read beat request
cmdIf_rdData_ack  out  1  read beat data valid (registered)
cmdIf_rdData  out  DATA_W  read beat data (registered)
rgn_addr  out  ADDR_W  current beat address, shared by all regions
rgn_wrData  out  DATA_W  equals cmdIf_wrData
rgn_wrReq  out  NUM_RGN  one-hot write strobe
rgn_rdReq  out  NUM_RGN  one-hot read strobe
rgn_rdData  in  NUM_RGN*DATA_W  per-region read data, sampled in the rdReq cycle
rgn_sel  out  3  index of the latched region (status)

Behaviour:
- Reset is synchronous, on sw_rst at the sys_clk edge. All of the following are 0 after reset:
  - cur_state=IDLE
  - addr_r, rgn_sel, rd_pend, beat_err
  - cmdIf_rdData, cmdIf_rdData_ack
  - all strobes and acks
- sw_rst asserted mid-beat aborts the beat. No rdData_ack follows.
- Decode: hit[i] = (addr >= BASE[i]) && (addr <= LIMIT[i]). The lowest hit index wins on overlap.
- States: IDLE, ACTIVE, ERR.
- IDLE: on trEn&&req, assert cmdIf_ack in the same cycle and load addr_r<=cmdIf_addr.
  - Any hit: rgn_sel<=winner, go to ACTIVE.
  - No hit: cmdIf_err=1 with the ack, go to ERR.
- ACTIVE/ERR priority, highest first: trEn&&wrData_req, then trEn&&rdData_req, then trEn&&req (re-decode as in IDLE, allowed in any state, no IDLE pass needed).
- ACTIVE/ERR: a cycle with none of the three requests returns to IDLE.
- Write beat (ACTIVE, beat_err=0): cmdIf_wrData_ack=1 and rgn_wrReq[rgn_sel]=1 in the same cycle; addr_r<=addr_r+ADDR_INCR. One beat per cycle.
- Read beat (ACTIVE, beat_err=0), two cycles per beat:
  - Cycle 1 (rd_pend=0): rgn_rdReq[rgn_sel]=1, cmdIf_rdData<=rgn_rdData[rgn_sel], rd_pend<=1.
  - Cycle 2: cmdIf_rdData_ack=1, addr_r<=addr_r+ADDR_INCR, rd_pend<=0.
  - If rdData_req is held, the next beat starts in cycle 3.
- Window overrun: beat_err = (addr_r > LIMIT[rgn_sel]) || carry out of the ADDR_W increment. The carry is latched until the next cmd load.
  - beat_err=1 write: wrData_ack and err=1, no wrReq, address still increments.
  - beat_err=1 read: same 2-cycle timing, no rdReq, cmdIf_rdData<=0, err=1 with rdData_ack.
- ERR state: every beat is completed as an error beat, using the same timing as above.
- A rd_pend beat always completes (ack in cycle 2) even if rdData_req drops or wrData_req rises. The write waits one cycle.
- cmdIf_rdData holds its value between acks. rgn_addr=addr_r at all times.

Test Plan:
- req addr=0x0800 -> ack+err=0 same cycle, rgn_sel=1. Then 3 wrData beats 0xA,0xB,0xC -> rgn_wrReq=3'b010 on 3 consecutive cycles at rgn_addr 0x800/0x804/0x808, each with wrData_ack.
- req addr=0x0920, rdData_req held 2 beats, rgn_rdData[0]=0x11 then 0x22 -> rdReq[0] in cycles 1 and 3, rdData_ack in cycles 2 and 4 with 0x11 and 0x22, addr 0x920 then 0x924.
- req addr=0x0500 (unmapped) -> ack with err=1. A following wrData beat gets wrData_ack+err=1 with no rgn_wrReq; a read beat returns 0 with err=1.
- req addr=0x0918, 2 write beats -> beat 1 (0x918) normal to region 1; beat 2 (0x91C > 0x91B) acked with err=1 and no strobe.
- In ACTIVE region 0, new req addr=0x1004 -> immediate ack, rgn_sel=2, next beat strobes rgn_wrReq[2] at 0x1004. A cycle with no request -> IDLE.
- sw_rst asserted in read cycle 1 -> no rdData_ack; all outputs 0 on the next cycle; state IDLE.
